// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from an upstream byte FIFO and serialises each one
// as an asynchronous UART frame (start, 8 data LSB first, optional parity, stop).
// Bit timing comes from an internal clock-cycle divider.
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_en,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned IDX_W  = 3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
  localparam logic             PAR_INIT = 1'(PARITY_ODD);
  localparam logic             PAR_ON   = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic [DATA_W-1:0]   r_shift;
  logic                r_par;
  logic                r_tx;
  logic                r_busy;

  state_t              w_state_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [IDX_W-1:0]    w_idx_nxt;
  logic [DATA_W-1:0]   w_shift_nxt;
  logic                w_par_nxt;
  logic                w_tx_nxt;
  logic                w_last;

  // State register; reset aborts any frame in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, datapath next values and state-decoded outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_par_nxt   = r_par;
    w_last      = (r_cnt == CNT_LAST);
    fifo_rd     = 1'b0;
    tx_done     = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (tx_en && !fifo_empty) begin
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        fifo_rd     = 1'b1;
        w_shift_nxt = fifo_data;
        w_par_nxt   = PAR_INIT;
        w_idx_nxt   = '0;
        w_cnt_nxt   = '0;
        w_state_nxt = S_START;
      end
      S_START: begin
        if (w_last) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_last) begin
          w_cnt_nxt   = '0;
          w_par_nxt   = r_par ^ r_shift[0];
          w_shift_nxt = {1'b0, r_shift[DATA_W-1:1]};
          w_idx_nxt   = r_idx + IDX_W'(1);
          if (r_idx == IDX_LAST) begin
            w_state_nxt = PAR_ON ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (w_last) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        tx_done = w_last;
        if (w_last) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase

    // Line level for the state being entered, so tx lines up with the state.
    unique case (w_state_nxt)
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = w_shift_nxt[0];
      S_PARITY: w_tx_nxt = w_par_nxt;
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  // Baud counter, bit index, shift register, parity and registered line outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_par   <= w_par_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  assign tx   = r_tx;
  assign busy = r_busy;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: three transmitters (no parity, even, odd) fed by behavioural
// FIFOs; a monitor decodes each serial line against frames built from the bytes.
module tb_fifo_uart_tx;

  localparam int unsigned CPB  = 4;
  localparam int unsigned NDUT = 3;
  localparam int unsigned PE [NDUT] = '{0, 1, 1};
  localparam int unsigned PO [NDUT] = '{0, 0, 1};

  localparam int K_TIMEOUT = 1;
  localparam int K_MARK    = 2;
  localparam int K_QUIET   = 3;
  localparam int K_RD16    = 4;
  localparam int K_FRAMES0 = 5;

  logic clk;
  logic reset;
  logic tx_en;

  logic [NDUT-1:0] w_tx;
  logic [NDUT-1:0] w_busy;
  logic [NDUT-1:0] w_done;
  logic [NDUT-1:0] f_rd;
  logic [NDUT-1:0] f_empty;
  logic [7:0]      f_data [NDUT];

  // Behavioural FIFOs and expected-byte scoreboards, one per transmitter.
  logic [7:0] fmem [NDUT][64];
  logic [7:0] emem [NDUT][64];
  int fwr [NDUT] = '{0, 0, 0};
  int frd [NDUT] = '{0, 0, 0};
  int ewr [NDUT] = '{0, 0, 0};
  int erd [NDUT] = '{0, 0, 0};

  logic       push_v;
  logic [7:0] push_b;

  int total = 0;
  int bad   = 0;

  int req_id   = 0;
  int seen_id  = 0;
  int req_kind = 0;
  int req_arg  = 0;
  logic idle_chk;
  logic no_rd_chk;

  // Monitor state.
  int   c       [NDUT] = '{0, 0, 0};
  int   gap     [NDUT] = '{0, 0, 0};
  int   starts  [NDUT] = '{0, 0, 0};
  int   frames  [NDUT] = '{0, 0, 0};
  int   rd_cnt  [NDUT] = '{0, 0, 0};
  int   rd_base [NDUT] = '{0, 0, 0};
  bit   active  [NDUT];
  bit   post    [NDUT];
  bit   have_prev [NDUT];
  bit   gap_exact [NDUT];
  bit   prev_rd [NDUT];
  logic [7:0] cur [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    fifo_uart_tx #(
      .CLKS_PER_BIT(CPB),
      .PARITY_EN   (PE[g]),
      .PARITY_ODD  (PO[g])
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .tx_en     (tx_en),
      .fifo_empty(f_empty[g]),
      .fifo_data (f_data[g]),
      .fifo_rd   (f_rd[g]),
      .tx        (w_tx[g]),
      .busy      (w_busy[g]),
      .tx_done   (w_done[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NDUT; i++) begin
      f_empty[i] = (fwr[i] == frd[i]);
      f_data[i]  = fmem[i][frd[i] % 64];
    end
  end

  // FIFO model: pushes also enter the scoreboard; pops follow fifo_rd; reset flushes.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NDUT; i++) frd[i] <= fwr[i];
    end else begin
      for (int i = 0; i < NDUT; i++) begin
        if (push_v) begin
          fmem[i][fwr[i] % 64] <= push_b;
          fwr[i]               <= fwr[i] + 1;
          emem[i][ewr[i] % 64] <= push_b;
          ewr[i]               <= ewr[i] + 1;
        end
        if (f_rd[i]) frd[i] <= frd[i] + 1;
      end
    end
  end

  // Expected line level for frame slot 'slot' (0 = start bit).
  function automatic logic exp_bit(input logic [7:0] b, input int unsigned pe,
                                   input int unsigned po, input int slot);
    logic [7:0] v;
    v = b;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return v[slot-1];
    if (slot == 9 && pe != 0) return (^v) ^ po[0];
    return 1'b1;
  endfunction

  task automatic chk(input string nm, input int i, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s dut%0d act=%0d exp=%0d t=%0t", nm, i, act, exp, $time);
    end
  endtask

  // Monitor: decodes each line cycle by cycle and services check requests.
  always @(negedge clk) begin
    if (req_id != seen_id) begin
      seen_id = req_id;
      case (req_kind)
        K_TIMEOUT: begin
          total++;
          bad++;
          $display("FAIL timeout phase=%0d act=expired exp=event", req_arg);
        end
        K_MARK: for (int i = 0; i < NDUT; i++) rd_base[i] = rd_cnt[i];
        K_QUIET: for (int i = 0; i < NDUT; i++) begin
          chk("rd_vs_frames", i, rd_cnt[i], starts[i]);
          chk("sb_drained", i, ewr[i] - erd[i], 0);
          chk("quiet_busy", i, int'(w_busy[i]), 0);
        end
        K_RD16: for (int i = 0; i < NDUT; i++)
          chk("burst_rd_pulses", i, rd_cnt[i] - rd_base[i], 16);
        K_FRAMES0: chk("txen_frames", 0, frames[0], req_arg);
        default: ;
      endcase
    end

    for (int i = 0; i < NDUT; i++) begin
      if (!reset) begin
        chk("rst_tx", i, int'(w_tx[i]), 1);
        chk("rst_busy", i, int'(w_busy[i]), 0);
        chk("rst_rd", i, int'(f_rd[i]), 0);
        chk("rst_done", i, int'(w_done[i]), 0);
        active[i] = 1'b0; post[i] = 1'b0; have_prev[i] = 1'b0; prev_rd[i] = 1'b0;
        gap[i] = 0; rd_cnt[i] = 0; starts[i] = 0;
        erd[i] = ewr[i];
      end else begin
        int flen;
        flen = (10 + int'(PE[i])) * int'(CPB);
        if (f_rd[i]) begin
          chk("rd_when_empty", i, int'(f_empty[i]), 0);
          chk("rd_width", i, int'(prev_rd[i]), 0);
          rd_cnt[i]++;
        end
        prev_rd[i] = f_rd[i];
        if (no_rd_chk) chk("rd_while_disabled", i, int'(f_rd[i]), 0);

        if (!active[i]) begin
          if (w_tx[i] == 1'b0) begin
            if (ewr[i] == erd[i]) begin
              chk("unexpected_frame", i, ewr[i] - erd[i], 1);
              cur[i] = 8'h00;
            end else begin
              cur[i] = emem[i][erd[i] % 64];
              erd[i]++;
            end
            if (have_prev[i]) begin
              if (gap_exact[i]) chk("b2b_gap", i, gap[i], 2);
              else chk("min_gap", i, int'(gap[i] >= 2), 1);
            end
            starts[i]++;
            active[i] = 1'b1;
            c[i] = 0;
          end else begin
            if (post[i]) begin
              chk("post_busy", i, int'(w_busy[i]), 0);
              gap_exact[i] = tx_en && !f_empty[i];
              post[i] = 1'b0;
            end
            if (idle_chk) begin
              chk("idle_busy", i, int'(w_busy[i]), 0);
              chk("idle_rd", i, int'(f_rd[i]), 0);
            end
            chk("idle_done", i, int'(w_done[i]), 0);
            gap[i]++;
          end
        end

        if (active[i]) begin
          chk("frame_tx", i, int'(w_tx[i]),
              int'(exp_bit(cur[i], PE[i], PO[i], c[i] / int'(CPB))));
          chk("frame_busy", i, int'(w_busy[i]), 1);
          chk("frame_done", i, int'(w_done[i]), int'(c[i] == flen - 1));
          c[i]++;
          if (c[i] == flen) begin
            active[i] = 1'b0; post[i] = 1'b1; have_prev[i] = 1'b1;
            gap[i] = 0;
            frames[i]++;
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] b);
    push_b = b;
    push_v = 1'b1;
    step(1);
    push_v = 1'b0;
  endtask

  task automatic req(input int kind, input int arg);
    req_kind = kind;
    req_arg  = arg;
    req_id++;
    step(2);
  endtask

  // Waits for every transmitter to be idle (and, if asked, its FIFO empty).
  task automatic wait_idle(input int budget, input bit need_empty, input int phase);
    int n;
    int stable;
    bit ok;
    n = 0;
    stable = 0;
    while (stable < 3 && n < budget) begin
      step(1);
      n++;
      ok = (w_busy == '0);
      if (need_empty) ok = ok && (f_empty == '1);
      stable = ok ? stable + 1 : 0;
    end
    if (stable < 3) req(K_TIMEOUT, phase);
  endtask

  int fb0;
  bit found;

  initial begin
    reset = 1'b0; tx_en = 1'b0; push_v = 1'b0; push_b = 8'h00;
    idle_chk = 1'b0; no_rd_chk = 1'b0;
    step(5);

    // Released with an empty FIFO: line stays idle.
    reset = 1'b1;
    idle_chk = 1'b1;
    step(40);
    idle_chk = 1'b0;

    // Directed bytes (0xA5, 0x07) through all three parity configurations.
    tx_en = 1'b1;
    push(8'hA5);
    wait_idle(300, 1'b1, 1);
    push(8'h07);
    wait_idle(300, 1'b1, 2);
    req(K_QUIET, 0);

    // Random single bytes with random spacing.
    for (int k = 0; k < 8; k++) begin
      push(8'($urandom));
      step(int'($urandom_range(0, 50)));
    end
    wait_idle(2000, 1'b1, 3);
    req(K_QUIET, 0);

    // Sixteen queued bytes drained back to back.
    tx_en = 1'b0;
    req(K_MARK, 0);
    for (int k = 0; k < 16; k++) push(8'(k));
    tx_en = 1'b1;
    wait_idle(3000, 1'b1, 4);
    req(K_RD16, 0);
    req(K_QUIET, 0);

    // tx_en dropped during the data bits of the fourth byte on dut0.
    tx_en = 1'b0;
    fb0 = frames[0];
    for (int k = 0; k < 6; k++) push(8'($urandom));
    tx_en = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 2000 && !found; n++) begin
      if (active[0] && frames[0] - fb0 == 3 && c[0] >= int'(2 * CPB) && c[0] < int'(8 * CPB))
        found = 1'b1;
      else
        step(1);
    end
    if (!found) req(K_TIMEOUT, 5);
    tx_en = 1'b0;
    wait_idle(600, 1'b0, 6);
    no_rd_chk = 1'b1;
    step(100);
    req(K_FRAMES0, fb0 + 4);
    no_rd_chk = 1'b0;
    tx_en = 1'b1;
    wait_idle(2000, 1'b1, 7);
    req(K_QUIET, 0);

    // Reset during data bit 4 of dut0, then fresh frames afterwards.
    for (int k = 0; k < 4; k++) push(8'($urandom));
    found = 1'b0;
    for (int n = 0; n < 1000 && !found; n++) begin
      if (active[0] && c[0] == int'(5 * CPB + 1)) found = 1'b1;
      else step(1);
    end
    if (!found) req(K_TIMEOUT, 8);
    reset = 1'b0;
    step(3);
    reset = 1'b1;
    step(2);
    push(8'h3C);
    push(8'hC3);
    wait_idle(1000, 1'b1, 9);
    req(K_QUIET, 0);

    // Random bytes with tx_en randomly toggling.
    for (int k = 0; k < 20; k++) begin
      push(8'($urandom));
      tx_en = ($urandom_range(0, 3) != 0);
      step(int'($urandom_range(0, 60)));
    end
    tx_en = 1'b1;
    wait_idle(4000, 1'b1, 10);
    req(K_QUIET, 0);

    step(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
